// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone encodings, responder state type and default widths
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_ADDR_WIDTH = 26;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK
   } wb_resp_state_t;

endpackage

// File: rtl/wb_mem_responder_if.sv
// rtl/wb_mem_responder_if.sv - Wishbone B3 bus bundle between a master and the memory responder
interface wb_mem_responder_if
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) ();

   logic                    wb_cyc_i;
   logic                    wb_stb_i;
   logic                    wb_we_i;
   logic [ADDR_WIDTH-1:0]   wb_addr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH/8-1:0] wb_sel_i;
   logic [2:0]              wb_cti_i;
   logic                    wb_ack_o;
   logic [DATA_WIDTH-1:0]   wb_dat_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      input  wb_ack_o, wb_dat_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i,
      output wb_ack_o, wb_dat_o
   );

endinterface

// File: rtl/wb_byte_ram.sv
// rtl/wb_byte_ram.sv - DEPTH x DATA_WIDTH storage with per-byte write enable and registered read
module wb_byte_ram
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int DEPTH      = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]      wdata_i,
   input  logic [DATA_WIDTH/8-1:0]    be_i,
   input  logic                       re_i,
   input  logic [$clog2(DEPTH)-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]      rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage is deliberately not reset so contents survive a bus reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (be_i[b]) begin
               mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B3 memory responder with wait states and incrementing bursts
module wb_mem_responder
   import wb_pkg::*;
#(
   parameter int                    DATA_WIDTH  = WB_DATA_WIDTH,
   parameter int                    ADDR_WIDTH  = WB_ADDR_WIDTH,
   parameter int                    DEPTH       = 1024,
   parameter int                    WAIT_STATES = 2,
   parameter logic [DATA_WIDTH-1:0] OOR_DATA    = 32'hDEAD_BEEF
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wb_mem_responder_if.slave wb,
   output logic              busy_o,
   output logic [15:0]       beat_cnt_o
);

   localparam int         IDX_W     = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   wb_resp_state_t    state_q, state_d;
   logic [3:0]        wait_cnt_q, wait_cnt_d;
   logic [IDX_W-1:0]  cur_addr_q, cur_addr_d;
   logic              oor_q, oor_d;
   logic              we_q, we_d;
   logic              rd_oor_q, rd_oor_d;
   logic [15:0]       beat_cnt_q, beat_cnt_d;

   logic              req;
   logic [IDX_W-1:0]  req_idx;
   logic              req_oor;
   logic              ram_we;
   logic              ram_re;
   logic [IDX_W-1:0]  ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic              unused_addr_bits;

   assign req              = wb.wb_cyc_i & wb.wb_stb_i;
   assign req_idx          = wb.wb_addr_i[2 +: IDX_W];
   assign req_oor          = |wb.wb_addr_i[ADDR_WIDTH-1:2+IDX_W];
   assign unused_addr_bits = ^wb.wb_addr_i[1:0];

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      cur_addr_d = cur_addr_q;
      oor_d      = oor_q;
      we_d       = we_q;
      rd_oor_d   = rd_oor_q;
      beat_cnt_d = beat_cnt_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      ram_raddr  = cur_addr_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               cur_addr_d = req_idx;
               oor_d      = req_oor;
               we_d       = wb.wb_we_i;
               if (WAIT_STATES == 0) begin
                  state_d   = ACK;
                  ram_re    = 1'b1;
                  ram_raddr = req_idx;
                  rd_oor_d  = req_oor;
               end else begin
                  state_d    = WAIT;
                  wait_cnt_d = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
            end else if (wait_cnt_q == 4'd0) begin
               state_d  = ACK;
               ram_re   = 1'b1;
               rd_oor_d = oor_q;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end
         ACK: begin
            if (!req) begin
               state_d = IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q + 16'd1;
               ram_we     = we_q & ~oor_q;
               // Burst beats prefetch the next word so ack can stay high every cycle.
               if (wb.wb_cti_i == CTI_INCR) begin
                  cur_addr_d = cur_addr_q + 1'b1;
                  if (!we_q) begin
                     ram_re    = 1'b1;
                     ram_raddr = cur_addr_q + 1'b1;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         cur_addr_q <= '0;
         oor_q      <= 1'b0;
         we_q       <= 1'b0;
         rd_oor_q   <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         cur_addr_q <= cur_addr_d;
         oor_q      <= oor_d;
         we_q       <= we_d;
         rd_oor_q   <= rd_oor_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   wb_byte_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk_i   (wb_clk_i),
      .rst_n_i (wb_rst_i),
      .we_i    (ram_we),
      .waddr_i (cur_addr_q),
      .wdata_i (wb.wb_dat_i),
      .be_i    (wb.wb_sel_i),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // Both terms are registered; the flag only changes when read data is loaded.
   assign wb.wb_dat_o = rd_oor_q ? OOR_DATA : ram_rdata;
   assign wb.wb_ack_o = (state_q == ACK);
   assign busy_o      = (state_q != IDLE);
   assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Wishbone B3 slave (responder) that terminates the master-side bus driven by the testbench wishbone master.
- Backs a local word-addressed memory of DEPTH words with byte-select writes.
- Supports programmable wait states and linear incrementing bursts (CTI 010).
- Used as the reference target for master-side verification and as a stand-in for the SDRAM controller front end.

Parameters:
- DATA_WIDTH, 32, bus data width; SEL width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, byte address width of wb_addr_i.
- DEPTH, 1024, memory words; power of two.
- WAIT_STATES, 2, cycles inserted before the first ack of a cycle; legal range 0..15.
- OOR_DATA, 32'hDEAD_BEEF, read data returned for out-of-range addresses.

Ports:
- wb_clk_i  in  1  bus clock; all logic on posedge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  DATA_WIDTH/8  byte enables.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_ack_o  out  1  transfer acknowledge.
- wb_dat_o  out  DATA_WIDTH  read data, registered.
- busy_o  out  1  high whenever FSM is not IDLE.
- beat_cnt_o  out  16  count of accepted beats; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (wb_rst_i low, asynchronous):
  - wb_ack_o = 0, wb_dat_o = 0, busy_o = 0, beat_cnt_o = 0, FSM = IDLE.
  - Memory contents are not cleared.
  - Reset asserted mid-cycle drops ack immediately; no write commits.
- Request: cyc & stb sampled high at edge k while in IDLE. Latch cur_addr = wb_addr_i[2 +: log2(DEPTH)] and oor = (upper address bits nonzero).
- FSM states:
  - IDLE -> WAIT when WAIT_STATES > 0.
  - IDLE -> ACK when WAIT_STATES = 0.
  - WAIT: a 4-bit down-counter expires; at edge k+WAIT_STATES move to ACK and drive wb_ack_o = 1.
  - ACK: wb_ack_o high.
- Beat acceptance: any edge where wb_ack_o = 1 and cyc & stb = 1.
  - Write: mem[cur_addr] byte lanes with wb_sel_i set take wb_dat_i. Out-of-range writes are dropped but still acked.
  - beat_cnt_o increments by 1.
- Read data:
  - wb_dat_o is loaded with mem[cur_addr] (or OOR_DATA when out of range) on the edge that asserts ack.
  - wb_dat_o holds its last value when not acking.
- Burst continuation: at acceptance, if wb_cti_i = 010, stay in ACK (ack stays high, zero wait), cur_addr increments by 1 word, and for reads wb_dat_o <= mem[cur_addr+1].
  - Address wraps modulo DEPTH.
  - The first beat out of range makes the whole burst out of range.
- Burst termination: at acceptance with wb_cti_i = 000 or 111, go to IDLE and drop ack at that edge.
  - Classic cycles therefore produce exactly a one-cycle ack pulse.
  - A request still present in the cycle after ack is not re-sampled until IDLE is reached.
- Abort: cyc or stb low while in WAIT or ACK -> go to IDLE, ack = 0, no write, no count.
- wb_we_i is latched at request and is fixed for the whole burst.

Decomposition:
- Shared package wb_pkg holds:
  - CTI encoding constants CTI_CLASSIC, CTI_INCR, CTI_EOB.
  - typedef enum wb_resp_state_t {IDLE, WAIT, ACK}.
  - Default widths DATA_WIDTH and ADDR_WIDTH.
- One sub-module, wb_byte_ram: a DEPTH x DATA_WIDTH memory with per-byte write enable and synchronous read. It keeps storage separate from the handshake FSM.

Test Plan:
- Classic write then read, WAIT_STATES = 2: write addr 0x10, data 0xA5A5_1234, sel 1111; read addr 0x10.
  - Ack rises exactly 2 cycles after the request edge and is 1 cycle wide.
  - Read returns 0xA5A5_1234; beat_cnt_o = 2.
- Byte select: preload 0xFFFF_FFFF at addr 0x20, then write 0x1122_3344 with sel 0101. Read returns 0xFF22_FF44.
- Incrementing burst, WAIT_STATES = 0: 4-beat write at 0x40 (data 1,2,3,4; CTI 010,010,010,111), then 4-beat read burst.
  - Ack is held 4 consecutive cycles.
  - Read data sequence is 1,2,3,4; beat_cnt_o increments by 8 in total.
- Out of range: read at byte address DEPTH*4.
  - Acked after WAIT_STATES cycles; returns 0xDEAD_BEEF.
  - A prior write to the same address does not alias into word 0.
- Abort and reset: drop cyc during WAIT -> no ack, busy_o falls, memory unchanged, count unchanged.
  - Assert wb_rst_i low during a burst ACK -> ack and busy_o go to 0 asynchronously before the next edge; beat_cnt_o = 0.
- Counter wrap: force 65536 classic accepted beats -> beat_cnt_o wraps to 0 with no stall.
